// File: rtl/clock_display_mux.sv
// clock_display_mux: captures binary HH:MM:SS, converts to BCD and scans it onto an 8-digit 7-segment display
module clock_display_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic       valid_i,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    logic [4:0]    r_hours;
    logic [5:0]    r_minutes;
    logic [5:0]    r_seconds;
    logic          r_bad_h, r_bad_m, r_bad_s;
    logic [3:0]    r_ht, r_hu, r_mt, r_mu, r_st, r_su;
    logic          r_dash_h, r_dash_m, r_dash_s;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [3:0]    w_digit;
    logic          w_dash;
    logic [6:0]    w_code;
    logic [6:0]    w_seg;

    // Snapshot the time fields on each strobe and flag any out-of-range field
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
            r_bad_h   <= 1'b0;
            r_bad_m   <= 1'b0;
            r_bad_s   <= 1'b0;
        end else if (valid_i) begin
            r_hours   <= hours_i;
            r_minutes <= minutes_i;
            r_seconds <= seconds_i;
            r_bad_h   <= hours_i > 5'd23;
            r_bad_m   <= minutes_i > 6'd59;
            r_bad_s   <= seconds_i > 6'd59;
        end
    end

    // Split each snapshot field into tens/units one cycle after capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ht     <= '0;
            r_hu     <= '0;
            r_mt     <= '0;
            r_mu     <= '0;
            r_st     <= '0;
            r_su     <= '0;
            r_dash_h <= 1'b0;
            r_dash_m <= 1'b0;
            r_dash_s <= 1'b0;
        end else begin
            r_ht     <= 4'(r_hours / 5'd10);
            r_hu     <= 4'(r_hours % 5'd10);
            r_mt     <= 4'(r_minutes / 6'd10);
            r_mu     <= 4'(r_minutes % 6'd10);
            r_st     <= 4'(r_seconds / 6'd10);
            r_su     <= 4'(r_seconds % 6'd10);
            r_dash_h <= r_bad_h;
            r_dash_m <= r_bad_m;
            r_dash_s <= r_bad_s;
        end
    end

    // Prescaler sets the dwell time of each digit; index walks 0..7 on each wrap
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
            r_idx   <= (r_presc == P_LAST) ? r_idx + 1'b1 : r_idx;
        end
    end

    // Pick the BCD digit and dash flag belonging to the current index
    always_comb begin
        w_digit = (r_idx == 3'd0) ? r_su :
                  (r_idx == 3'd1) ? r_st :
                  (r_idx == 3'd2) ? r_mu :
                  (r_idx == 3'd3) ? r_mt :
                  (r_idx == 3'd4) ? r_hu :
                  (r_idx == 3'd5) ? r_ht : 4'd0;
        w_dash  = (r_idx == 3'd0 || r_idx == 3'd1) ? r_dash_s :
                  (r_idx == 3'd2 || r_idx == 3'd3) ? r_dash_m :
                  (r_idx == 3'd4 || r_idx == 3'd5) ? r_dash_h : 1'b0;
    end

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit
    always_comb begin
        w_code = 7'h7F;
        case (w_digit)
            4'd0: w_code = 7'h40;
            4'd1: w_code = 7'h79;
            4'd2: w_code = 7'h24;
            4'd3: w_code = 7'h30;
            4'd4: w_code = 7'h19;
            4'd5: w_code = 7'h12;
            4'd6: w_code = 7'h02;
            4'd7: w_code = 7'h78;
            4'd8: w_code = 7'h00;
            4'd9: w_code = 7'h10;
            default: w_code = 7'h7F;
        endcase
        w_seg = w_dash ? 7'h3F : w_code;
    end

    // Register anode, segments and decimal point together so they never skew
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            an_o  <= 8'hFF;
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= (r_idx < 3'd6) ? ~(8'd1 << r_idx) : 8'hFF;
            seg_o <= (r_idx < 3'd6) ? w_seg : 7'h7F;
            dp_o  <= !(r_idx == 3'd2 || r_idx == 3'd4);
        end
    end
endmodule

// File: tb/tb_clock_display_mux.sv
// tb_clock_display_mux: directed, cycle-exact check of capture, BCD, dashes, scan and reset
module tb_clock_display_mux;
    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [4:0] hours_i = '0;
    logic [5:0] minutes_i = '0;
    logic [5:0] seconds_i = '0;
    logic       valid_i = 1'b0;
    logic [7:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    logic [7:0] an_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    logic [6:0] exp_seg [6];

    clock_display_mux #(.REFRESH_DIV(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .hours_i(hours_i), .minutes_i(minutes_i),
        .seconds_i(seconds_i), .valid_i(valid_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_all(input logic [6:0] v);
        for (int i = 0; i < 6; i++) exp_seg[i] = v;
    endtask

    task automatic set6(input logic [6:0] d5, d4, d3, d2, d1, d0);
        exp_seg[5] = d5; exp_seg[4] = d4; exp_seg[3] = d3;
        exp_seg[2] = d2; exp_seg[1] = d1; exp_seg[0] = d0;
    endtask

    task automatic step(input string tag);
        int idx;
        tick();
        k++;
        idx = ((k - 1) / 4) % 8;
        chk($sformatf("%s an k=%0d", tag, k), an_o, an_exp[idx]);
        chk($sformatf("%s seg k=%0d", tag, k), seg_o, idx > 5 ? 7'h7F : exp_seg[idx]);
        chk($sformatf("%s dp k=%0d", tag, k), dp_o, (idx == 2 || idx == 4) ? 1'b0 : 1'b1);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic put(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hours_i = h; minutes_i = m; seconds_i = s;
    endtask

    initial begin
        tick();
        tick();
        chk("rst an", an_o, 8'hFF);
        chk("rst seg", seg_o, 7'h7F);
        chk("rst dp", dp_o, 1'b1);
        rstn_i = 1'b1;
        k = 0;
        set_all(7'h40);
        steps("zero", 32);

        put(5'd13, 6'd47, 6'd9);
        valid_i = 1'b1;
        step("cap1 old");
        valid_i = 1'b0;
        step("cap1 old");
        set6(7'h79, 7'h30, 7'h19, 7'h78, 7'h40, 7'h10);
        steps("t134709", 30);

        put(5'd22, 6'd22, 6'd22);
        steps("hold", 32);
        valid_i = 1'b1;
        step("cap2 old");
        valid_i = 1'b0;
        step("cap2 old");
        set_all(7'h24);
        steps("t222222", 30);

        put(5'd24, 6'd60, 6'd59);
        valid_i = 1'b1;
        step("cap3 old");
        valid_i = 1'b0;
        step("cap3 old");
        set6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h12, 7'h10);
        steps("range", 30);

        put(5'd0, 6'd0, 6'd0);
        valid_i = 1'b1;
        step("clr old");
        valid_i = 1'b0;
        step("clr old");
        set_all(7'h40);
        steps("cleared", 30);

        put(5'd1, 6'd2, 6'd3);
        valid_i = 1'b1;
        step("b2b a");
        put(5'd4, 6'd5, 6'd6);
        step("b2b b");
        put(5'd7, 6'd8, 6'd9);
        exp_seg[0] = 7'h30;
        step("b2b c");
        valid_i = 1'b0;
        exp_seg[0] = 7'h02;
        step("b2b d");
        set6(7'h40, 7'h78, 7'h40, 7'h00, 7'h40, 7'h10);
        steps("t070809", 28);

        put(5'd13, 6'd47, 6'd9);
        valid_i = 1'b1;
        step("cap4 old");
        valid_i = 1'b0;
        step("cap4 old");
        set6(7'h79, 7'h30, 7'h19, 7'h78, 7'h40, 7'h10);
        steps("t134709b", 11);
        chk("pre-rst an idx3", an_o, 8'hF7);
        rstn_i = 1'b0;
        #1;
        chk("async an", an_o, 8'hFF);
        chk("async seg", seg_o, 7'h7F);
        chk("async dp", dp_o, 1'b1);
        tick();
        tick();
        chk("held an", an_o, 8'hFF);
        rstn_i = 1'b1;
        k = 0;
        set_all(7'h40);
        steps("post-rst", 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Downstream consumer of the time-of-day counter: captures the binary hours/minutes/seconds it produces, converts each field to two BCD digits, and time-multiplexes them onto an 8-digit common-anode 7-segment display as HH.MM.SS. It is the only block that drives the board's anode, segment and decimal-point pins.

## Interface
- REFRESH_DIV, 100000: clk_i cycles each digit stays selected (1 ms at 100 MHz); legal range 2..2^20.
- clk_i  in  1  system clock (100 MHz)
- rstn_i  in  1  asynchronous active-low reset
- hours_i  in  5  binary hours from the time counter, 0..23 legal
- minutes_i  in  6  binary minutes, 0..59 legal
- seconds_i  in  6  binary seconds, 0..59 legal
- valid_i  in  1  single-cycle strobe: time fields are stable and should be captured
- an_o  out  8  digit anodes, active low, one-hot-low or all-high
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active low
- dp_o  out  1  decimal point, active low

## Operation
- Capture: on any cycle with valid_i=1, hours_i/minutes_i/seconds_i are registered into snapshot registers. Without valid_i the snapshot holds; input changes between strobes are ignored.
- Range check: a field outside its legal range (hours>23, minutes>59, seconds>59) is flagged; both digits of that field show dash (only segment g lit) until a valid capture clears it. Each field is checked independently.
- BCD: each snapshot field is split into tens/units (tens = field/10, units = field mod 10) and registered in a BCD stage one cycle after capture.
- Digit map: idx 5,4 = hours tens,units; 3,2 = minutes tens,units; 1,0 = seconds tens,units; idx 7,6 blank. No leading-zero suppression (05 shows as 0 and 5).
- Decimal points: lit (dp_o=0) on idx 4 and idx 2 only, forming HH.MM.SS; dark elsewhere.
- Scan: prescaler counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and digit index advances 0→1→…→7→0.
- Output for current idx: an_o has bit idx low, others high; for blank idx 7,6 an_o=8'hFF, seg_o=7'h7F, dp_o=1.
- Segment codes (active low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, dash=0x3F.

## Timing
- Reset (async assert, sync-free deassert handled by codebase reset sync): an_o=8'hFF, seg_o=7'h7F, dp_o=1, prescaler=0, digit idx=0, snapshots=0, BCD=0, range flags clear. After reset the display shows 00.00.00.
- All outputs registered; an_o, seg_o, dp_o change on the same edge, never skewed.
- Latency: valid_i sampled at edge N → snapshot valid after N → BCD valid after N+1 → reflected in outputs no later than the edge after N+1 on which that digit is (or stays) selected; a currently selected digit updates mid-slot at edge N+2.
- First digit slot after reset: idx 0 driven from edge 1; idx advances every REFRESH_DIV cycles; full frame = 8*REFRESH_DIV cycles.
- valid_i on consecutive cycles: every cycle captures; last value wins.
- Reset mid-scan or mid-capture: all state returns to reset values immediately; pending capture discarded.
- Wrap 23:59:59→00:00:00 is just a new capture; no special handling.

## Test plan
- Reset, REFRESH_DIV=4, no valid_i → an_o cycles FE,FD,FB,F7,EF,DF,FF,FF every 4 cycles; seg_o=0x40 on idx 0..5, dp_o=0 only on idx 4 and 2, seg_o=0x7F on idx 6,7.
- valid_i with 13:47:09 → idx5..0 seg_o = 0x79,0x30,0x19,0x78,0x40,0x10; update visible at valid edge+2 on the selected digit.
- Change inputs to 22:22:22 without valid_i → display keeps previous value for a full frame; then strobe → shows 22.22.22.
- Capture hours=24, minutes=60, seconds=59 → idx5..2 seg_o=0x3F, idx1,0 = 0x12,0x10; next capture 00:00:00 clears dashes.
- Assert rstn_i low mid-slot on idx 3 with 13:47:09 shown → same cycle an_o=FF, seg_o=7F, dp_o=1; after release shows 00.00.00 starting at idx 0.
- Back-to-back valid_i on 3 cycles with 01:02:03, 04:05:06, 07:08:09 → display settles at 07.08.09 with no intermediate glitch on unselected digits.
